// File: rtl/neuron_grid_param.sv
// neuron_grid_param: leaky integrate-and-fire neuron array for one core.
// Once per tick, each neuron walks every axon and accumulates weighted
// spikes. It then applies its leak and decides whether to fire. A spike is
// emitted as a 30-bit destination packet toward the local router.
module neuron_grid_param #(
   parameter int CORE_NUMBER = 0,
   parameter int NUM_AXONS   = 256,
   parameter int NUM_NEURONS = 256,
   parameter int POT_W       = 9,
   localparam int PARAM_W    = NUM_AXONS + 8*POT_W + 31,
   localparam int NW         = $clog2(NUM_NEURONS),
   localparam int AW         = $clog2(NUM_AXONS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic [NUM_AXONS-1:0] axon_spikes,
   input  logic                 local_buffers_full,
   input  logic                 param_wen,
   input  logic [NW-1:0]        param_address,
   input  logic [PARAM_W-1:0]   param_data_in,
   input  logic                 neuron_inst_wen,
   input  logic [AW-1:0]        neuron_inst_address,
   input  logic [1:0]           neuron_inst_data_in,
   output logic                 error,
   output logic                 scheduler_set,
   output logic                 scheduler_clr,
   output logic                 done,
   output logic [29:0]          packet_out,
   output logic                 spike_out_valid
);

   // Param word field offsets, counted from the LSB.
   localparam int MODE_BIT = 30;
   localparam int RVAL_LSB = 31;
   localparam int NTHR_LSB = 31 + POT_W;
   localparam int PTHR_LSB = 31 + 2*POT_W;
   localparam int LEAK_LSB = 31 + 3*POT_W;
   localparam int W_LSB    = 31 + 4*POT_W;
   localparam int CONN_LSB = 31 + 8*POT_W;

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_INTEG, S_LEAK, S_FIRE, S_DONE} state_t;

   state_t state, state_next;

   logic [NW-1:0]              n_idx;
   logic [AW-1:0]              a_idx;
   logic [NUM_AXONS-1:0]       spikes;
   logic [PARAM_W-1:0]         param_mem [NUM_NEURONS];
   logic [1:0]                 type_mem  [NUM_AXONS];
   logic [NUM_NEURONS*POT_W-1:0] pot;

   logic [PARAM_W-1:0]         row;
   logic [NUM_AXONS-1:0]       conn;
   logic signed [POT_W-1:0]    weights [4];
   logic signed [POT_W-1:0]    leak, pos_thr, neg_thr, reset_val, cur_v, w_sel;
   logic                       reset_mode, hit, fire, advance, last_axon, last_neuron;
   logic [29:0]                dest;

   // Packet tagging is done downstream; the core index is carried but unused.
   logic [31:0] unused_core_number;
   assign unused_core_number = 32'(CORE_NUMBER);

   // Saturating signed add clamped to the POT_W range.
   function automatic logic signed [POT_W-1:0] sat_add(input logic signed [POT_W-1:0] x,
                                                       input logic signed [POT_W-1:0] y);
      logic signed [POT_W:0] s;
      s = {x[POT_W-1], x} + {y[POT_W-1], y};
      if (s[POT_W] != s[POT_W-1])
         sat_add = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
      else
         sat_add = s[POT_W-1:0];
   endfunction

   // Saturating signed subtract clamped to the POT_W range.
   function automatic logic signed [POT_W-1:0] sat_sub(input logic signed [POT_W-1:0] x,
                                                       input logic signed [POT_W-1:0] y);
      logic signed [POT_W:0] s;
      s = {x[POT_W-1], x} - {y[POT_W-1], y};
      if (s[POT_W] != s[POT_W-1])
         sat_sub = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
      else
         sat_sub = s[POT_W-1:0];
   endfunction

   // Decode the current neuron's parameter row and the per-axon weight choice.
   always_comb begin
      row        = param_mem[n_idx];
      conn       = row[CONN_LSB +: NUM_AXONS];
      for (int k = 0; k < 4; k++)
         weights[k] = row[W_LSB + k*POT_W +: POT_W];
      leak       = row[LEAK_LSB +: POT_W];
      pos_thr    = row[PTHR_LSB +: POT_W];
      neg_thr    = row[NTHR_LSB +: POT_W];
      reset_val  = row[RVAL_LSB +: POT_W];
      reset_mode = row[MODE_BIT];
      dest       = row[29:0];
      cur_v      = pot[n_idx*POT_W +: POT_W];
      w_sel      = weights[type_mem[a_idx]];
      hit        = spikes[a_idx] & conn[a_idx];
      fire       = (cur_v >= pos_thr);
      last_axon  = (a_idx == AW'(NUM_AXONS-1));
      last_neuron = (n_idx == NW'(NUM_NEURONS-1));
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // Next-state and strobe outputs; a firing neuron holds FIRE while the router is full.
   always_comb begin
      state_next      = state;
      scheduler_set   = 1'b0;
      scheduler_clr   = 1'b0;
      done            = 1'b0;
      spike_out_valid = 1'b0;
      packet_out      = '0;
      advance         = 1'b0;
      unique case (state)
         S_IDLE:  if (tick) state_next = S_LATCH;
         S_LATCH: begin
            scheduler_set = 1'b1;
            state_next    = S_INTEG;
         end
         S_INTEG: if (last_axon) state_next = S_LEAK;
         S_LEAK:  state_next = S_FIRE;
         S_FIRE: begin
            if (fire) begin
               packet_out      = dest;
               spike_out_valid = !local_buffers_full;
            end
            advance = !fire || !local_buffers_full;
            if (advance) state_next = last_neuron ? S_DONE : S_INTEG;
         end
         S_DONE: begin
            done          = 1'b1;
            scheduler_clr = 1'b1;
            state_next    = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Axon and neuron walk counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_idx <= '0;
         a_idx <= '0;
      end else begin
         case (state)
            S_LATCH: begin
               n_idx <= '0;
               a_idx <= '0;
            end
            S_INTEG: if (!last_axon) a_idx <= a_idx + 1'b1;
            S_FIRE: if (advance) begin
               a_idx <= '0;
               if (!last_neuron) n_idx <= n_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Snapshot of the scheduler slot taken while requesting it.
   always_ff @(posedge clk) begin
      if (state == S_LATCH) spikes <= axon_spikes;
   end

   // Membrane potential update: integrate, leak, then fire/reset or floor.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pot <= '0;
      end else begin
         case (state)
            S_INTEG: if (hit) pot[n_idx*POT_W +: POT_W] <= sat_add(cur_v, w_sel);
            S_LEAK:  pot[n_idx*POT_W +: POT_W] <= sat_add(cur_v, leak);
            S_FIRE: begin
               if (fire && !local_buffers_full)
                  pot[n_idx*POT_W +: POT_W] <= reset_mode ? sat_sub(cur_v, pos_thr) : reset_val;
               else if (!fire && (cur_v < neg_thr))
                  pot[n_idx*POT_W +: POT_W] <= neg_thr;
            end
            default: ;
         endcase
      end
   end

   // Configuration RAM writes; accepted in any state.
   always_ff @(posedge clk) begin
      if (param_wen)       param_mem[param_address]      <= param_data_in;
      if (neuron_inst_wen) type_mem[neuron_inst_address] <= neuron_inst_data_in;
   end

   // Sticky protocol error for ticks or writes arriving mid-timestep.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         error <= 1'b0;
      else if ((state != S_IDLE) && (tick || param_wen || neuron_inst_wen))
         error <= 1'b1;
   end

endmodule

// File: tb/tb_neuron_grid_param.sv
// Self-checking bench for neuron_grid_param with 4 axons, 2 neurons, 9-bit potentials.
module tb_neuron_grid_param;

   localparam int A  = 4;
   localparam int N  = 2;
   localparam int P  = 9;
   localparam int PW = A + 8*P + 31;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           tick = 1'b0;
   logic [A-1:0]   axon_spikes = '0;
   logic           local_buffers_full = 1'b0;
   logic           param_wen = 1'b0;
   logic [0:0]     param_address = '0;
   logic [PW-1:0]  param_data_in = '0;
   logic           neuron_inst_wen = 1'b0;
   logic [1:0]     neuron_inst_address = '0;
   logic [1:0]     neuron_inst_data_in = '0;
   logic           error, scheduler_set, scheduler_clr, done, spike_out_valid;
   logic [29:0]    packet_out;

   neuron_grid_param #(.CORE_NUMBER(0), .NUM_AXONS(A), .NUM_NEURONS(N), .POT_W(P)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .axon_spikes(axon_spikes),
      .local_buffers_full(local_buffers_full), .param_wen(param_wen),
      .param_address(param_address), .param_data_in(param_data_in),
      .neuron_inst_wen(neuron_inst_wen), .neuron_inst_address(neuron_inst_address),
      .neuron_inst_data_in(neuron_inst_data_in), .error(error),
      .scheduler_set(scheduler_set), .scheduler_clr(scheduler_clr), .done(done),
      .packet_out(packet_out), .spike_out_valid(spike_out_valid));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int          m_conn [N];
   int          m_w    [N][4];
   int          m_leak [N], m_pthr [N], m_nthr [N], m_rval [N], m_rmode [N];
   logic [29:0] m_dest [N];
   int          m_type [A];
   int          m_pot  [N];
   logic [29:0] exp_q [$];

   // Observed per-run results
   logic [29:0] got_q [$];
   int          got_cyc_q [$];
   int          done_cyc, done_cnt, set_cyc, clr_cyc, pkt_nz;

   function automatic int sat(input int v);
      if (v > 255)  return 255;
      if (v < -256) return -256;
      return v;
   endfunction

   task automatic model_tick(input logic [A-1:0] sp);
      for (int n = 0; n < N; n++) begin
         int v;
         v = m_pot[n];
         for (int a = 0; a < A; a++)
            if (sp[a] && (((m_conn[n] >> a) & 1) == 1)) v = sat(v + m_w[n][m_type[a]]);
         v = sat(v + m_leak[n]);
         if (v >= m_pthr[n]) begin
            exp_q.push_back(m_dest[n]);
            v = (m_rmode[n] != 0) ? sat(v - m_pthr[n]) : m_rval[n];
         end else if (v < m_nthr[n]) begin
            v = m_nthr[n];
         end
         m_pot[n] = v;
      end
   endtask

   function automatic logic [PW-1:0] build_row(input int n);
      return {4'(m_conn[n]), 9'(m_w[n][3]), 9'(m_w[n][2]), 9'(m_w[n][1]), 9'(m_w[n][0]),
              9'(m_leak[n]), 9'(m_pthr[n]), 9'(m_nthr[n]), 9'(m_rval[n]),
              1'(m_rmode[n]), m_dest[n]};
   endfunction

   function automatic int read_pot(input int n);
      logic signed [P-1:0] v;
      v = dut.pot[n*P +: P];
      return int'(v);
   endfunction

   task automatic write_neuron(input int n);
      @(negedge clk);
      param_wen = 1'b1; param_address = 1'(n); param_data_in = build_row(n);
      @(negedge clk);
      param_wen = 1'b0;
   endtask

   task automatic write_types();
      for (int a = 0; a < A; a++) begin
         @(negedge clk);
         neuron_inst_wen = 1'b1; neuron_inst_address = 2'(a); neuron_inst_data_in = 2'(m_type[a]);
      end
      @(negedge clk);
      neuron_inst_wen = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      for (int n = 0; n < N; n++) m_pot[n] = 0;
   endtask

   // Neuron 0: small firing setup; neuron 1: never fires, never floors.
   task automatic set_base(input int rmode);
      m_conn[0] = 4'b0101; m_w[0][0] = 5; m_w[0][1] = 4; m_w[0][2] = 0; m_w[0][3] = 0;
      m_leak[0] = 0; m_pthr[0] = 8; m_nthr[0] = -256; m_rval[0] = 0; m_rmode[0] = rmode;
      m_dest[0] = 30'h2AAAAAAA;
      m_conn[1] = 0; for (int k = 0; k < 4; k++) m_w[1][k] = 0;
      m_leak[1] = 0; m_pthr[1] = 255; m_nthr[1] = -256; m_rval[1] = 0; m_rmode[1] = 0;
      m_dest[1] = 30'h155;
      m_type[0] = 0; m_type[1] = 2; m_type[2] = 1; m_type[3] = 3;
      write_types();
      write_neuron(0);
      write_neuron(1);
   endtask

   // Issue one tick and monitor cycle by cycle (cycle 1 = LATCH).
   task automatic run_tick(input int full_from, input int full_len, input int xtick_cyc, input int wen_cyc);
      got_q.delete(); got_cyc_q.delete();
      done_cyc = -1; done_cnt = 0; set_cyc = -1; clr_cyc = -1; pkt_nz = 0;
      @(negedge clk); tick = 1'b1;
      @(posedge clk); #1; tick = 1'b0;
      for (int k = 1; k <= 150; k++) begin
         local_buffers_full = (k >= full_from) && (k < full_from + full_len);
         tick = (k == xtick_cyc);
         param_wen = (k == wen_cyc);
         if (k == wen_cyc) begin param_address = 1'b1; param_data_in = build_row(1); end
         @(negedge clk);
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
         if (scheduler_set && set_cyc < 0) set_cyc = k;
         if (scheduler_clr && clr_cyc < 0) clr_cyc = k;
         if (spike_out_valid) begin got_q.push_back(packet_out); got_cyc_q.push_back(k); end
         if (packet_out != 0) pkt_nz++;
         if (done_cyc >= 0 && k >= done_cyc + 3) break;
         @(posedge clk); #1;
      end
      tick = 1'b0; local_buffers_full = 1'b0; param_wen = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({error, scheduler_set, scheduler_clr, done, spike_out_valid, packet_out} !== '0) begin
         n_errors++; $display("FAIL reset_outputs: got %b want all zero",
            {error, scheduler_set, scheduler_clr, done, spike_out_valid, packet_out});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int n = 0; n < N; n++) m_pot[n] = 0;
      set_base(0);
      axon_spikes = 4'b0101;
      // Tick, then a second tick in cycle 2 to raise error, then reset in cycle 4.
      @(negedge clk); tick = 1'b1;
      @(posedge clk); #1; tick = 1'b0;
      @(posedge clk); #1; tick = 1'b1;
      @(posedge clk); #1; tick = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (error !== 1'b1) begin n_errors++; $display("FAIL reset_pre_error: got %b want 1", error); end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({error, scheduler_set, scheduler_clr, done, spike_out_valid, packet_out} !== '0) begin
         n_errors++; $display("FAIL reset_async_outputs: got %b want all zero",
            {error, scheduler_set, scheduler_clr, done, spike_out_valid, packet_out});
      end
      n_checks++;
      if (read_pot(0) !== 0 || read_pot(1) !== 0) begin
         n_errors++; $display("FAIL reset_pot_clear: got %0d/%0d want 0/0", read_pot(0), read_pot(1));
      end
      @(negedge clk); reset_n = 1'b1;
      for (int n = 0; n < N; n++) m_pot[n] = 0;
      model_tick(axon_spikes);
      exp_q.delete();
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (done_cyc !== 14) begin n_errors++; $display("FAIL reset_next_done: got %0d want 14", done_cyc); end
   endtask

   task automatic test_fire_mode0();
      set_base(0);
      axon_spikes = 4'b0101;
      model_tick(axon_spikes);
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (set_cyc !== 1) begin n_errors++; $display("FAIL m0_sched_set: got %0d want 1", set_cyc); end
      n_checks++;
      if (got_q.size() !== 1 || got_cyc_q[0] !== 7) begin
         n_errors++; $display("FAIL m0_spike_cycle: got %0d pkts first at %0d want 1 at 7",
                              got_q.size(), (got_q.size() > 0) ? got_cyc_q[0] : -1);
      end
      n_checks++;
      if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
         n_errors++; $display("FAIL m0_packet: got %h want %h", (got_q.size() > 0) ? got_q[0] : 30'h0, exp_q[0]);
      end
      n_checks++;
      if (read_pot(0) !== m_pot[0]) begin n_errors++; $display("FAIL m0_v0: got %0d want %0d", read_pot(0), m_pot[0]); end
      n_checks++;
      if (done_cyc !== 14 || clr_cyc !== 14 || done_cnt !== 1) begin
         n_errors++; $display("FAIL m0_done: got done %0d clr %0d cnt %0d want 14 14 1", done_cyc, clr_cyc, done_cnt);
      end
      exp_q.delete();
   endtask

   task automatic test_fire_mode1();
      set_base(1);
      axon_spikes = 4'b0101;
      model_tick(axon_spikes);
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (read_pot(0) !== m_pot[0]) begin n_errors++; $display("FAIL m1_v0: got %0d want %0d", read_pot(0), m_pot[0]); end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_errors++; $display("FAIL m1_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      set_base(0);
      axon_spikes = 4'b0101;
      model_tick(axon_spikes);
      run_tick(7, 5, 0, 0);
      n_checks++;
      if (got_q.size() !== 1 || got_cyc_q[0] !== 12) begin
         n_errors++; $display("FAIL bp_spike: got %0d pkts first at %0d want 1 at 12",
                              got_q.size(), (got_q.size() > 0) ? got_cyc_q[0] : -1);
      end
      n_checks++;
      if (done_cyc !== 19) begin n_errors++; $display("FAIL bp_done: got %0d want 19", done_cyc); end
      n_checks++;
      if (pkt_nz !== 6) begin n_errors++; $display("FAIL bp_packet_hold: got %0d cycles want 6", pkt_nz); end
      n_checks++;
      if (read_pot(0) !== m_pot[0]) begin n_errors++; $display("FAIL bp_v0: got %0d want %0d", read_pot(0), m_pot[0]); end
      exp_q.delete();
   endtask

   task automatic test_saturation();
      do_reset();
      set_base(0);
      m_conn[0] = 4'b0001; m_w[0][0] = 200; m_pthr[0] = 255; m_rval[0] = 7;
      write_neuron(0);
      axon_spikes = 4'b0001;
      model_tick(axon_spikes);
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (read_pot(0) !== 200 || got_q.size() !== 0) begin
         n_errors++; $display("FAIL sat_pre: got V %0d pkts %0d want 200 0", read_pot(0), got_q.size());
      end
      m_w[0][0] = 255;
      write_neuron(0);
      model_tick(axon_spikes);
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (got_q.size() !== 1 || got_q[0] !== 30'h2AAAAAAA) begin
         n_errors++; $display("FAIL sat_fire: got %0d pkts want 1 of 2aaaaaaa", got_q.size());
      end
      n_checks++;
      if (read_pot(0) !== m_pot[0]) begin n_errors++; $display("FAIL sat_v0: got %0d want %0d", read_pot(0), m_pot[0]); end
      exp_q.delete();
   endtask

   task automatic test_floor();
      m_w[0][0] = -200; m_leak[0] = -100; m_nthr[0] = -150; m_pthr[0] = 255;
      write_neuron(0);
      axon_spikes = 4'b0001;
      model_tick(axon_spikes);
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (read_pot(0) !== -150) begin n_errors++; $display("FAIL floor_v0: got %0d want -150", read_pot(0)); end
      n_checks++;
      if (got_q.size() !== 0) begin n_errors++; $display("FAIL floor_nospike: got %0d want 0", got_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_error();
      do_reset();
      set_base(0);
      n_checks++;
      if (error !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b want 0", error); end
      axon_spikes = 4'b0101;
      model_tick(axon_spikes);
      run_tick(0, 0, 5, 6);
      n_checks++;
      if (error !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b want 1", error); end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== 14) begin
         n_errors++; $display("FAIL err_done: got cnt %0d at %0d want 1 at 14", done_cnt, done_cyc);
      end
      model_tick(axon_spikes);
      run_tick(0, 0, 0, 0);
      n_checks++;
      if (error !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", error); end
      exp_q.delete();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < N; n++) begin
         m_conn[n] = int'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) m_w[n][k] = int'($urandom_range(0, 511)) - 256;
         m_leak[n]  = int'($urandom_range(0, 40)) - 20;
         m_pthr[n]  = int'($urandom_range(0, 355)) - 100;
         m_nthr[n]  = int'($urandom_range(0, 256)) - 256;
         m_rval[n]  = int'($urandom_range(0, 511)) - 256;
         m_rmode[n] = int'($urandom_range(0, 1));
         m_dest[n]  = 30'($urandom);
      end
      for (int a = 0; a < A; a++) m_type[a] = int'($urandom_range(0, 3));
      write_types();
      write_neuron(0);
      write_neuron(1);
      for (int t = 0; t < 8; t++) begin
         axon_spikes = 4'($urandom);
         exp_q.delete();
         model_tick(axon_spikes);
         run_tick(0, 0, 0, 0);
         n_checks++;
         if (got_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", t, got_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < got_q.size(); i++) begin
               n_checks++;
               if (got_q[i] !== exp_q[i]) begin
                  n_errors++; $display("FAIL rnd_packet[%0d.%0d]: got %h want %h", t, i, got_q[i], exp_q[i]);
               end
            end
         end
         for (int n = 0; n < N; n++) begin
            n_checks++;
            if (read_pot(n) !== m_pot[n]) begin
               n_errors++; $display("FAIL rnd_v[%0d.%0d]: got %0d want %0d", t, n, read_pot(n), m_pot[n]);
            end
         end
         n_checks++;
         if (done_cyc !== 14) begin n_errors++; $display("FAIL rnd_done[%0d]: got %0d want 14", t, done_cyc); end
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_fire_mode0();
      test_fire_mode1();
      test_backpressure();
      test_saturation();
      test_floor();
      test_error();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
